booth_seq_mult: RTL and testbench

Sequential 32x32 signed radix-4 Booth multiplier. It is the consumer side of the Booth digit / partial-product interface. It recodes multiplier b into 3-bit Booth triplets, one per cycle, forms each partial product of multiplicand a, and accumulates them into a 64-bit product. It is the area-lean alternative to the parallel Wallace-tree multiplier and sits behind a valid/ready handshake on both sides.

---
 rtl/booth_seq_mult_pkg.sv | 27 ++
 rtl/booth_seq_mult_if.sv | 28 ++
 rtl/booth_seq_mult_pp_gen.sv | 28 ++
 rtl/booth_seq_mult.sv | 109 ++++++++++
 tb/tb_booth_seq_mult.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_seq_mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package booth_seq_mult_pkg;

  localparam int unsigned DefaultWidth = 32;

  // Booth triplet codes {y[i+1], y[i], y[i-1]}
  localparam logic [2:0] TripZeroLo  = 3'b000;
  localparam logic [2:0] TripPosOneA = 3'b001;
  localparam logic [2:0] TripPosOneB = 3'b010;
  localparam logic [2:0] TripPosTwo  = 3'b011;
  localparam logic [2:0] TripNegTwo  = 3'b100;
  localparam logic [2:0] TripNegOneA = 3'b101;
  localparam logic [2:0] TripNegOneB = 3'b110;
  localparam logic [2:0] TripZeroHi  = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } booth_state_e;

  // Negative digit: top bit set, but not the all-ones zero code
  function automatic logic booth_neg(input logic [2:0] t);
    return t[2] & ~(t[1] & t[0]);
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Operand/product handshake bundle for the Booth multiplier.
interface booth_seq_mult_if
  import booth_seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;

  // Producer of operands / consumer of products
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  // The multiplier itself
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/booth_seq_mult_pp_gen.sv
// Radix-4 Booth partial-product generator: triplet -> one's-complemented
// magnitude plus a separate +1 correction bit for negative digits.
module booth_pp_gen
  import booth_seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [2:0]       triplet_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH:0]   pp_o,
  output logic             neg_o
);

  logic [WIDTH:0] mag;

  // Select |digit|*x, sign-extended to WIDTH+1 bits, then invert for negative digits
  always_comb begin
    mag = '0;
    unique case (triplet_i)
      TripPosOneA, TripPosOneB, TripNegOneA, TripNegOneB: mag = {x_i[WIDTH-1], x_i};
      TripPosTwo, TripNegTwo:                             mag = {x_i, 1'b0};
      default:                                            mag = '0;
    endcase
    neg_o = booth_neg(triplet_i);
    pp_o  = neg_o ? ~mag : mag;
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit per cycle,
// WIDTH/2 iterations, valid/ready handshake on operands and product.
module booth_seq_mult
  import booth_seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic             clk,
  input logic             rst,
  booth_seq_mult_if.slave bus
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned AccW = 2 * WIDTH + 2;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  booth_state_e           state_q, state_d;
  logic [WIDTH-1:0]       x_q, x_d;
  logic [WIDTH:0]         y_q, y_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     product_q, product_d;

  logic [WIDTH:0]         pp;
  logic                   neg;
  logic [AccW-1:0]        pp_ext;
  logic [AccW-1:0]        addend;
  logic [AccW-1:0]        corr;
  logic [AccW-1:0]        acc_sum;
  logic                   last;

  booth_pp_gen #(
    .WIDTH (WIDTH)
  ) u_pp_gen (
    .triplet_i (y_q[2:0]),
    .x_i       (x_q),
    .pp_o      (pp),
    .neg_o     (neg)
  );

  // Weight the current partial product by 4^cnt and add the two's-complement correction
  always_comb begin
    pp_ext  = {{(AccW - WIDTH - 1){pp[WIDTH]}}, pp};
    addend  = pp_ext << {cnt_q, 1'b0};
    corr    = {{(AccW - 1){1'b0}}, neg} << {cnt_q, 1'b0};
    acc_sum = acc_q + addend + corr;
    last    = (cnt_q == CntW'(N - 1));
  end

  // Next-state: controller, multiplier shift register and accumulator
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          x_d     = bus.a;
          y_d     = {bus.b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_sum;
        y_d   = {{2{y_q[WIDTH]}}, y_q[WIDTH:2]};
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          product_d = acc_sum[2*WIDTH-1:0];
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult with a queue-based scoreboard.
module tb_booth_seq_mult;

  localparam int unsigned W = 32;
  localparam int unsigned N = W / 2;

  logic clk = 1'b0;
  logic rst;

  booth_seq_mult_if #(.WIDTH(W)) bus ();

  booth_seq_mult #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  // Watchdog against a hung simulation
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] ra, input logic [31:0] rb);
    longint sa;
    longint sb;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    return sa * sb;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer operands until accepted; push expected product on acceptance
  task automatic send(input logic [31:0] sa, input logic [31:0] sb, input logic [63:0] exp,
                      output int waits, output bit ok);
    waits = 0;
    bus.a = sa;
    bus.b = sb;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && waits < 200) begin
      tick();
      waits++;
    end
    n_checks++;
    ok = (bus.in_ready === 1'b1);
    if (ok) begin
      exp_q.push_back(exp);
    end else begin
      n_fail++;
      $display("FAIL send_accept: in_ready got %b required 1 within 200 cycles", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for a product with out_ready high and compare against the scoreboard
  task automatic receive(input string name, output int waits);
    logic [63:0] exp;
    waits = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && waits < 200) begin
      tick();
      waits++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid got %b required 1", name, bus.out_valid);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: product got %h required none pending", name, bus.product);
    end else begin
      exp = exp_q.pop_front();
      if (bus.product !== exp) begin
        n_fail++;
        $display("FAIL %s_product: got %h required %h", name, bus.product, exp);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    n_checks += 3;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
    end
    if (bus.product !== 64'd0) begin
      n_fail++; $display("FAIL reset_product: got %h required 0", bus.product);
    end
    rst = 1'b0;
    tick();
  endtask

  // 3*5: in_ready low for the whole operation, out_valid for exactly one cycle N edges later
  task automatic test_latency();
    int w;
    bit ok;
    logic [63:0] exp;
    bus.out_ready = 1'b1;
    send(32'd3, 32'd5, 64'd15, w, ok);
    for (int k = 0; k <= int'(N); k++) begin
      n_checks += 2;
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL latency_in_ready k=%0d: got %b required 0", k, bus.in_ready);
      end
      if (bus.out_valid !== (k == int'(N))) begin
        n_fail++;
        $display("FAIL latency_out_valid k=%0d: got %b required %b", k, bus.out_valid,
                 (k == int'(N)));
      end
      if (k < int'(N)) tick();
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL latency_scoreboard: got empty queue required one entry");
    end else begin
      exp = exp_q.pop_front();
      if (bus.product !== exp) begin
        n_fail++; $display("FAIL latency_product: got %h required %h", bus.product, exp);
      end
    end
    tick();
    n_checks += 2;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_one_cycle: out_valid got %b required 0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL latency_idle: in_ready got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_corners();
    logic [31:0] ta [8] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
                            32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF9};
    logic [31:0] tb [8] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                            32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0009};
    logic [63:0] te [8] = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000, 64'd1, 64'd0,
                            64'hC000_0000_8000_0000, 64'h0000_0000_8000_0000,
                            64'h3FFF_FFFF_0000_0001, 64'hFFFF_FFFF_FFFF_FFC1};
    int w;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      send(ta[i], tb[i], te[i], w, ok);
      receive("corner", w);
    end
  endtask

  task automatic test_backpressure();
    int w;
    bit ok;
    logic [63:0] exp;
    bus.out_ready = 1'b0;
    send(32'd1000, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_F448, w, ok);
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    bus.a = 32'd5;
    bus.b = 32'd5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks += 3;
      if (bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_out_valid i=%0d: got %b required 1", i, bus.out_valid);
      end
      if (bus.product !== exp) begin
        n_fail++; $display("FAIL bp_product i=%0d: got %h required %h", i, bus.product, exp);
      end
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready i=%0d: got %b required 0", i, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks += 2;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release_valid: got %b required 0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b required 1", bus.in_ready);
    end
    send(32'd5, 32'd5, 64'd25, w, ok);
    n_checks++;
    if (w != 0) begin
      n_fail++; $display("FAIL bp_next_accept: waits got %0d required 0", w);
    end
    receive("bp_next", w);
  endtask

  task automatic test_reset_mid();
    int w;
    int w2;
    bit ok;
    bus.out_ready = 1'b1;
    send(32'd11, 32'd13, 64'd143, w, ok);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    n_checks += 3;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out_valid: got %b required 0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_ready: got %b required 1", bus.in_ready);
    end
    if (bus.product !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_product: got %h required 0", bus.product);
    end
    send(32'hFFFF_FFF9, 32'd9, 64'hFFFF_FFFF_FFFF_FFC1, w, ok);
    receive("rstmid", w2);
    n_checks += 2;
    if (w != 0) begin
      n_fail++; $display("FAIL rstmid_accept: waits got %0d required 0", w);
    end
    if (w2 != int'(N)) begin
      n_fail++; $display("FAIL rstmid_latency: cycles got %0d required %0d", w2, N);
    end
  endtask

  task automatic test_random();
    localparam int M = 1500;
    fork
      begin : driver
        int w;
        bit ok;
        logic [31:0] ra;
        logic [31:0] rb;
        for (int i = 0; i < M; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          ra = $urandom;
          rb = $urandom;
          if (i % 16 == 0) ra = 32'h8000_0000;
          if (i % 23 == 0) rb = 32'h8000_0000;
          send(ra, rb, ref_mul(ra, rb), w, ok);
          if (!ok) break;
        end
      end
      begin : monitor
        int got;
        int cyc;
        logic [63:0] exp;
        got = 0;
        cyc = 0;
        while (got < M && cyc < M * 40) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid === 1'b1 && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL random_dup: product got %h required none pending", bus.product);
            end else begin
              exp = exp_q.pop_front();
              if (bus.product !== exp) begin
                n_fail++;
                $display("FAIL random_product #%0d: got %h required %h", got, bus.product, exp);
              end
            end
            got++;
          end
          tick();
          cyc++;
        end
        n_checks++;
        if (got != M) begin
          n_fail++; $display("FAIL random_count: got %0d products required %0d", got, M);
        end
      end
    join
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_leftover: pending got %0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
